// File: rtl/search_scheduler_if.sv
// search_scheduler_if: control/status bundle between the board glue and the search scheduler.
// master = board glue / lane side driving controls and flags; slave = search_scheduler.
interface search_scheduler_if #(
    parameter int unsigned LANES_LOG2 = 3,
    parameter int unsigned CNT_W      = 29
);
    localparam int unsigned LANES = 2 ** LANES_LOG2;

    logic                 enable;
    logic                 start;
    logic [CNT_W-1:0]     base_in;
    logic [CNT_W-1:0]     limit_in;
    logic [LANES-1:0]     lane_found;
    logic [CNT_W-1:0]     counter_out;
    logic                 issue_valid;
    logic                 busy;
    logic                 paused;
    logic                 found;
    logic                 done;
    logic [31:0]          found_candidate;
    logic [31:0]          issue_count;
    logic [31:0]          stall_count;

    modport master (
        output enable, start, base_in, limit_in, lane_found,
        input  counter_out, issue_valid, busy, paused, found, done,
               found_candidate, issue_count, stall_count
    );

    modport slave (
        input  enable, start, base_in, limit_in, lane_found,
        output counter_out, issue_valid, busy, paused, found, done,
               found_candidate, issue_count, stall_count
    );
endinterface

// File: rtl/search_scheduler.sv
// search_scheduler: issues block indices to the MD5 hash lanes, supports pause, inclusive
// range and drain, and attributes lane hits through a latency-matched issue history.
// Optional macro SEARCH_STATS_EN enables the issue/stall statistics counters; when it is
// undefined issue_count and stall_count are tied to zero.
module search_scheduler #(
    parameter int unsigned LANES_LOG2 = 3,
    parameter int unsigned CNT_W      = 29,
    parameter int unsigned PIPE_LAT   = 64
) (
    input logic              CLK,
    input logic              CPU_RESETN,
    search_scheduler_if.slave bus
);
    localparam int unsigned LANES  = 2 ** LANES_LOG2;
    localparam int unsigned DRN_W  = $clog2(PIPE_LAT + 1);
    localparam int unsigned CAND_W = CNT_W + LANES_LOG2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FOUND = 3'd4;
    localparam logic [2:0] S_EXH   = 3'd5;

    logic [2:0]          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_idx, w_idx_nxt;
    logic [CNT_W-1:0]    r_limit, w_limit_nxt;
    logic [DRN_W-1:0]    r_drain, w_drain_nxt;
    logic                r_issue_valid, w_issue_valid_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_paused, w_paused_nxt;
    logic                r_found, w_found_nxt;
    logic                r_done, w_done_nxt;
    logic [CAND_W-1:0]   r_cand, w_cand_nxt;
    logic [PIPE_LAT-1:0] r_hv;
    logic [CNT_W-1:0]    r_hi [PIPE_LAT];
    logic [LANES_LOG2-1:0] w_lane;
    logic                w_hit;

    // Lowest-numbered asserted lane wins attribution
    always_comb begin
        w_lane = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (bus.lane_found[i]) w_lane = LANES_LOG2'(i);
        end
    end

    // A hit needs a valid tail entry while a search is active
    assign w_hit = r_hv[PIPE_LAT-1] && (bus.lane_found != '0) &&
                   (r_state == S_RUN || r_state == S_PAUSE || r_state == S_DRAIN);

    // State register
    always_ff @(posedge CLK) begin
        if (!CPU_RESETN) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_limit_nxt = r_limit;
        w_drain_nxt = r_drain;
        w_found_nxt = r_found;
        w_done_nxt  = r_done;
        w_cand_nxt  = r_cand;
        case (r_state)
            S_IDLE, S_FOUND, S_EXH: begin
                if (bus.start) begin
                    w_idx_nxt   = bus.base_in;
                    w_limit_nxt = bus.limit_in;
                    w_found_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_cand_nxt  = '0;
                    if (bus.limit_in < bus.base_in) begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = DRN_W'(PIPE_LAT - 1);
                    end else if (bus.enable) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_PAUSE;
                    end
                end
            end
            S_RUN: begin
                if (r_idx == r_limit) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = DRN_W'(PIPE_LAT - 1);
                end else begin
                    w_idx_nxt = r_idx + CNT_W'(1);
                    if (!bus.enable) w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (bus.enable) w_state_nxt = S_RUN;
            end
            S_DRAIN: begin
                if (r_drain == '0) begin
                    w_state_nxt = S_EXH;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_drain_nxt = r_drain - DRN_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Match overrides every other transition in the same cycle
        if (w_hit) begin
            w_state_nxt = S_FOUND;
            w_idx_nxt   = r_idx;
            w_found_nxt = 1'b1;
            w_done_nxt  = 1'b1;
            w_cand_nxt  = {r_hi[PIPE_LAT-1], w_lane};
        end
        w_issue_valid_nxt = (w_state_nxt == S_RUN);
        w_paused_nxt      = (w_state_nxt == S_PAUSE);
        w_busy_nxt        = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE) ||
                            (w_state_nxt == S_DRAIN);
    end

    // Datapath and output registers
    always_ff @(posedge CLK) begin
        if (!CPU_RESETN) begin
            r_idx         <= '0;
            r_limit       <= '0;
            r_drain       <= '0;
            r_issue_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_paused      <= 1'b0;
            r_found       <= 1'b0;
            r_done        <= 1'b0;
            r_cand        <= '0;
        end else begin
            r_idx         <= w_idx_nxt;
            r_limit       <= w_limit_nxt;
            r_drain       <= w_drain_nxt;
            r_issue_valid <= w_issue_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_paused      <= w_paused_nxt;
            r_found       <= w_found_nxt;
            r_done        <= w_done_nxt;
            r_cand        <= w_cand_nxt;
        end
    end

    // History valid bits shift every cycle; reset and a hit flush them
    always_ff @(posedge CLK) begin
        if (!CPU_RESETN || w_hit) r_hv <= '0;
        else                      r_hv <= {r_hv[PIPE_LAT-2:0], r_issue_valid};
    end

    // History indices shift every cycle; only meaningful under their valid bit
    always_ff @(posedge CLK) begin
        r_hi[0] <= r_idx;
        for (int unsigned i = 1; i < PIPE_LAT; i++) r_hi[i] <= r_hi[i-1];
    end

    assign bus.counter_out     = r_idx;
    assign bus.issue_valid     = r_issue_valid;
    assign bus.busy            = r_busy;
    assign bus.paused          = r_paused;
    assign bus.found           = r_found;
    assign bus.done            = r_done;
    assign bus.found_candidate = 32'(r_cand);

`ifdef SEARCH_STATS_EN
    logic [31:0] r_issue_cnt, r_stall_cnt;
    logic        w_start_acc;

    assign w_start_acc = bus.start &&
                         (r_state == S_IDLE || r_state == S_FOUND || r_state == S_EXH);

    // Saturating issue/stall counters, cleared by an accepted start
    always_ff @(posedge CLK) begin
        if (!CPU_RESETN || w_start_acc) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_issue_valid && r_issue_cnt != '1)        r_issue_cnt <= r_issue_cnt + 32'd1;
            if (r_state == S_PAUSE && r_stall_cnt != '1)   r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.issue_count = r_issue_cnt;
    assign bus.stall_count = r_stall_cnt;
`else
    assign bus.issue_count = '0;
    assign bus.stall_count = '0;
`endif

endmodule

// File: doc/search_scheduler.md
Name: search_scheduler

Overview:
- Sequences the MD5 brute-force datapath: issues block indices to 2^LANES_LOG2 parallel hash lanes, one index per cycle; lane i hashes candidate {index, i}.
- Supports pause/resume, an inclusive search range and drain of in-flight work.
- Attributes lane found pulses back to the exact candidate through a latency-matched issue history.
- Sits between the board switch/LED glue and the lane pipelines; replaces ad-hoc counter/warm-up sequencing.

Parameters:
- LANES_LOG2, 3, log2 of lane count; LANES = 2^LANES_LOG2.
- CNT_W, 29, block index width; CNT_W + LANES_LOG2 = 32.
- PIPE_LAT, 64, cycles from counter_out being driven to the matching lane_found bit being valid (>= 2).

Ports:
- CLK  in  1  clock.
- CPU_RESETN  in  1  synchronous active-low reset.
- enable  in  1  level; 0 requests pause.
- start  in  1  one-cycle pulse; loads range and begins a search.
- base_in  in  CNT_W  first block index, inclusive; sampled on start.
- limit_in  in  CNT_W  last block index, inclusive; sampled on start.
- lane_found  in  LANES  per-lane match flags from the pipelines.
- counter_out  out  CNT_W  block index presented to all lanes.
- issue_valid  out  1  counter_out is a real issue this cycle.
- busy  out  1  state is RUN, PAUSE or DRAIN.
- paused  out  1  state is PAUSE.
- found  out  1  match captured; sticky.
- done  out  1  search ended (FOUND or EXHAUSTED).
- found_candidate  out  32  {block index, lane index} of the match.

Behaviour:
- Reset (CPU_RESETN=0 at a clock edge): state IDLE; all outputs 0; every history valid bit cleared.
- Reset mid-search drops all in-flight work. Stale lane_found pulses after reset are ignored because their history entries are invalid.
- States and transitions:
  - IDLE: on start, load base/limit. Go to RUN if enable=1, else PAUSE.
  - RUN: issue_valid=1 and counter_out=current index. If the issued index equals limit, go to DRAIN; else increment. If enable=0 and this is not the last index, go to PAUSE.
  - PAUSE: issue_valid=0; counter holds. Return to RUN when enable=1.
  - DRAIN: issue_valid=0. Wait PIPE_LAT cycles after the last issue, then go to EXHAUSTED.
  - FOUND / EXHAUSTED: terminal. start re-arms exactly as from IDLE. start in RUN/PAUSE/DRAIN is ignored.
- Issue timing: start seen at edge T gives counter_out=base and issue_valid=1 during cycle T+1.
- Issue history:
  - PIPE_LAT-deep shift register of {valid, index}. It shifts every cycle in every state, because the pipelines are free-running.
  - The entry issued in cycle k reaches the tail in cycle k+PIPE_LAT.
  - lane_found is qualified by the tail valid bit; bubbles never produce a match.
- Match capture:
  - When the tail is valid and lane_found != 0 in RUN, PAUSE or DRAIN, capture {tail index, lowest set lane index} into found_candidate on the next edge, set found=1 and done=1, and go to FOUND.
  - Issuing stops the same edge; the history is cleared of valids.
  - Match beats other transitions in the same cycle, including limit reached and enable=0.
- Empty range (limit_in < base_in): go to DRAIN with zero issues, then EXHAUSTED after PIPE_LAT cycles; found stays 0.
- No wrap: limit = all-ones is legal; the counter never increments past limit.
- found_candidate holds until the next start or reset. On start, found and done clear.
- Arithmetic: unsigned CNT_W compare and increment.

Optional Feature:
- Macro SEARCH_STATS_EN.
- When defined: adds outputs issue_count[31:0] (issue_valid cycles) and stall_count[31:0] (PAUSE cycles). Both clear on start and reset and saturate at all-ones.
- When undefined: both outputs exist but are tied to 0, with no counter logic.

Test Plan (PIPE_LAT=4, LANES_LOG2=3):
- Nominal hit: base=10, limit=20, enable=1, lane_found=8'b0000_0100 in the cycle index 13 reaches the tail -> found=1, done=1, found_candidate=(13<<3)|2=106, issue_valid drops.
- Exhaustion: base=0, limit=3, no matches -> exactly 4 issue_valid cycles (0..3), DRAIN for 4 cycles, then done=1, found=0, busy=0.
- Pause mid-run: enable=0 after index 5 issues for 6 cycles, then enable=1 -> counter_out resumes at 6. A match on index 5 arriving during PAUSE still gives found_candidate=40+lane.
- Bubble rejection: lane_found=8'hFF in cycles whose tail entry is invalid (pause bubbles, post-reset) -> found stays 0.
- Multi-lane priority and simultaneous limit: lane_found=8'b1001_0000 when the tail index equals limit=7 -> found_candidate=(7<<3)|4=60, state FOUND, not EXHAUSTED.
- Reset mid-search plus empty range: CPU_RESETN=0 during RUN gives all outputs 0 the next cycle; then start with base=9, limit=8 -> zero issues, EXHAUSTED after 4 cycles.
